// File: rtl/bus_pkg.sv
// Shared widths, FSM state type and the status register offset for bus_slave.
package bus_pkg;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 16;

  localparam logic [3:0] STATUS_OFFSET = 4'hF;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACK
  } state_e;

endpackage

// File: rtl/bus_regfile.sv
// NREGS x DATA_W register storage: synchronous write, combinational read, sync reset.
module bus_regfile
  import bus_pkg::*;
#(
  parameter int unsigned       NREGS       = 8,
  parameter logic [DATA_W-1:0] RESET_VALUE = '0
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              we,
  input  logic [3:0]        addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] regs_q [NREGS];

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        regs_q[i] <= RESET_VALUE;
      end
    end else if (we) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        if (addr == 4'(i)) begin
          regs_q[i] <= wdata;
        end
      end
    end
  end

  always_comb begin
    rdata = '0;
    for (int unsigned i = 0; i < NREGS; i++) begin
      if (addr == 4'(i)) begin
        rdata = regs_q[i];
      end
    end
  end

endmodule

// File: rtl/bus_slave.sv
// Memory-mapped register bank on the shared bus with wait states and req/ready handshake.
// Define BUS_SLAVE_STATUS_EN to map a transfer-count status register at BASE+4'hF.
module bus_slave
  import bus_pkg::*;
#(
  parameter logic [ADDR_W-1:0] BASE        = 16'hFFF0,
  parameter int unsigned       NREGS       = 8,
  parameter int unsigned       WAIT_STATES = 2,
  parameter logic [DATA_W-1:0] RESET_VALUE = 16'h0000
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req,
  input  logic              w,
  input  logic [ADDR_W-1:0] address,
  inout  wire  [DATA_W-1:0] data,
  output logic              ready
);

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [3:0]        off_q;
  logic              w_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              ready_q, ready_d;

  logic              accept;
  logic              enter;
  logic              hit;
  logic              status_hit;
  logic              rf_we;
  logic [DATA_W-1:0] rf_rdata;
  logic [DATA_W-1:0] rd_val;

  assign hit = (address[ADDR_W-1:4] == BASE[ADDR_W-1:4]) &&
               ((32'(address[3:0]) < NREGS) || status_hit);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    enter   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req && hit) begin
          accept = 1'b1;
          if (WAIT_STATES == 0) begin
            state_d = ACK;
          end else begin
            state_d = WAIT;
            cnt_d   = 4'(WAIT_STATES - 1);
          end
        end
      end
      WAIT: begin
        if (!req) begin
          state_d = IDLE;
        end else if (cnt_q == 4'd0) begin
          state_d = ACK;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ACK: begin
        // First ACK cycle with req still high performs the one-time write/capture.
        if (!req) begin
          state_d = IDLE;
        end else if (!ready_q) begin
          enter = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign ready_d = (state_q == ACK) && req;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      off_q   <= '0;
      w_q     <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      if (accept) begin
        off_q   <= address[3:0];
        w_q     <= w;
        wdata_q <= data;
      end
      if (enter) begin
        rdata_q <= rd_val;
      end
    end
  end

  // Status writes fall outside the regfile range and are dropped here.
  assign rf_we = enter && w_q && (32'(off_q) < NREGS);

  bus_regfile #(
    .NREGS       (NREGS),
    .RESET_VALUE (RESET_VALUE)
  ) u_regfile (
    .clock   (clock),
    .reset_n (reset_n),
    .we      (rf_we),
    .addr    (off_q),
    .wdata   (wdata_q),
    .rdata   (rf_rdata)
  );

`ifdef BUS_SLAVE_STATUS_EN
  logic [DATA_W-1:0] status_q;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      status_q <= '0;
    end else if (enter) begin
      status_q <= status_q + 16'd1;
    end
  end

  assign status_hit = (address[3:0] == STATUS_OFFSET);
  assign rd_val     = (off_q == STATUS_OFFSET) ? status_q : rf_rdata;
`else
  assign status_hit = 1'b0;
  assign rd_val     = rf_rdata;
`endif

  assign ready = ready_q;
  assign data  = (ready_q && !w_q) ? rdata_q : {DATA_W{1'bz}};

endmodule

// File: tb/tb_bus_slave.sv
// Randomised scoreboard bench for bus_slave: two instances (2 and 0 wait states).
module tb_bus_slave;

  localparam logic [15:0] BASE  = 16'hFFF0;
  localparam int          NREGS = 8;
  localparam int          WS0   = 2;
  localparam int          WS1   = 0;

  typedef struct {
    bit          rd;
    logic [15:0] val;
    int          due;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        req  [2];
  logic        w    [2];
  logic [15:0] addr [2];
  logic [15:0] drv  [2];
  logic        oe   [2];
  wire  [15:0] bus0, bus1;
  logic        rdy0, rdy1;

  int          cyc = 0;
  int          n_checks = 0;
  int          n_pass = 0;
  exp_t        q0[$], q1[$];
  logic [15:0] mem  [2][16];
  logic [15:0] scnt [2];
  logic        prev_rdy [2];
  bit          cur_read [2];
  logic [15:0] cur_exp  [2];

  assign bus0 = oe[0] ? drv[0] : 16'hzzzz;
  assign bus1 = oe[1] ? drv[1] : 16'hzzzz;

  bus_slave #(
    .BASE        (BASE),
    .NREGS       (NREGS),
    .WAIT_STATES (WS0),
    .RESET_VALUE (16'h0000)
  ) dut0 (
    .clock   (clock),
    .reset_n (reset_n),
    .req     (req[0]),
    .w       (w[0]),
    .address (addr[0]),
    .data    (bus0),
    .ready   (rdy0)
  );

  bus_slave #(
    .BASE        (BASE),
    .NREGS       (NREGS),
    .WAIT_STATES (WS1),
    .RESET_VALUE (16'h0000)
  ) dut1 (
    .clock   (clock),
    .reset_n (reset_n),
    .req     (req[1]),
    .w       (w[1]),
    .address (addr[1]),
    .data    (bus1),
    .ready   (rdy1)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic int ws_of(input int k);
    return (k == 0) ? WS0 : WS1;
  endfunction

  function automatic logic rdy(input int k);
    return (k == 0) ? rdy0 : rdy1;
  endfunction

  function automatic logic [15:0] busv(input int k);
    return (k == 0) ? bus0 : bus1;
  endfunction

  function automatic logic [15:0] probe();
    return 16'($urandom);
  endfunction

  function automatic bit is_hit(input logic [15:0] a);
    if ((a >> 4) != (BASE >> 4)) return 1'b0;
    if (int'(a[3:0]) < NREGS) return 1'b1;
`ifdef BUS_SLAVE_STATUS_EN
    if (a[3:0] == 4'hF) return 1'b1;
`endif
    return 1'b0;
  endfunction

  // Reference: plain arrays of register contents plus a completed-transfer count.
  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 16; i++) mem[k][i] = 16'h0000;
      scnt[k] = 16'h0000;
    end
  endfunction

  function automatic logic [15:0] model_read(input int k, input logic [15:0] a);
    if (a[3:0] == 4'hF) return scnt[k];
    return mem[k][a[3:0]];
  endfunction

  function automatic void model_commit(input int k, input bit wr, input logic [15:0] a,
                                       input logic [15:0] d);
    if (wr && int'(a[3:0]) < NREGS) mem[k][a[3:0]] = d;
    scnt[k] = scnt[k] + 16'd1;
  endfunction

  task automatic scramble(input int k);
    w[k]    = 1'($urandom_range(0, 1));
    addr[k] = 16'($urandom);
  endtask

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  // mode: 0 normal, 1 drop req in WAIT, 2 reset while ready is high.
  task automatic xfer(input int k, input bit wr, input logic [15:0] a, input logic [15:0] d,
                      input int mode, input int hold);
    bit   hit;
    bit   seen;
    exp_t e;
    hit = is_hit(a);
    tick();
    req[k]  = 1'b1;
    w[k]    = wr;
    addr[k] = a;
    drv[k]  = wr ? d : probe();
    oe[k]   = wr || !hit;
    if (hit && mode != 1) begin
      e.rd  = !wr;
      e.val = model_read(k, a);
      e.due = cyc + ws_of(k) + 2;
      if (k == 0) q0.push_back(e);
      else q1.push_back(e);
      model_commit(k, wr, a, d);
    end
    tick();
    drv[k] = probe();
    if (!hit) begin
      oe[k] = 1'b1;
      repeat (hold) tick();
      req[k] = 1'b0;
      tick();
      return;
    end
    oe[k] = wr;
    if (mode == 1) begin
      req[k] = 1'b0;
      oe[k]  = 1'b1;
      scramble(k);
      repeat (2) tick();
      return;
    end
    seen = 1'b0;
    for (int n = 0; n < ws_of(k) + 4 && !seen; n++) begin
      if (rdy(k)) seen = 1'b1;
      else begin
        scramble(k);
        tick();
      end
    end
    if (!seen) begin
      check("ready_timeout", 16'(rdy(k)), 16'd1);
      if (k == 0) q0.delete(q0.size() - 1);
      else q1.delete(q1.size() - 1);
      req[k] = 1'b0;
      oe[k]  = 1'b1;
      tick();
      return;
    end
    if (mode == 2) begin
      reset_n = 1'b0;
      oe[k]   = 1'b1;
      drv[k]  = probe();
      tick();
      check("reset_ready", 16'(rdy(k)), 16'd0);
      req[k]  = 1'b0;
      reset_n = 1'b1;
      model_reset();
      tick();
      return;
    end
    repeat (hold) begin
      scramble(k);
      tick();
    end
    req[k] = 1'b0;
    tick();
    check("ready_drop", 16'(rdy(k)), 16'd0);
    oe[k]  = 1'b1;
    drv[k] = probe();
  endtask

  task automatic do_reset();
    tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    model_reset();
  endtask

  // Monitor: pops the scoreboard on each rising ready and checks the bus every cycle.
  always @(negedge clock) begin
    for (int k = 0; k < 2; k++) begin
      logic        r;
      logic [15:0] b;
      exp_t        e;
      r = rdy(k);
      b = busv(k);
      if (r === 1'b1 && prev_rdy[k] !== 1'b1) begin
        if ((k == 0 ? q0.size() : q1.size()) == 0) begin
          check($sformatf("spurious_ready%0d", k), 16'(r), 16'd0);
        end else begin
          e = (k == 0) ? q0.pop_front() : q1.pop_front();
          check($sformatf("latency%0d", k), 16'(cyc), 16'(e.due));
          cur_read[k] = e.rd;
          cur_exp[k]  = e.val;
        end
      end
      if (r !== 1'b1) cur_read[k] = 1'b0;
      if (r === 1'b1 && cur_read[k]) check($sformatf("read_data%0d", k), b, cur_exp[k]);
      if (oe[k]) check($sformatf("bus_release%0d", k), b, drv[k]);
      prev_rdy[k] = r;
    end
  end

  initial begin
    for (int k = 0; k < 2; k++) begin
      req[k]      = 1'b0;
      w[k]        = 1'b0;
      addr[k]     = 16'h0000;
      drv[k]      = probe();
      oe[k]       = 1'b1;
      prev_rdy[k] = 1'b0;
      cur_read[k] = 1'b0;
      cur_exp[k]  = 16'h0000;
    end
    reset_n = 1'b0;
    model_reset();
    repeat (3) tick();
    check("reset_ready0", 16'(rdy0), 16'd0);
    check("reset_ready1", 16'(rdy1), 16'd0);
    reset_n = 1'b1;

    // Write then read back with two wait states.
    xfer(0, 1'b1, 16'hFFF3, 16'h71F0, 0, 0);
    xfer(0, 1'b0, 16'hFFF3, 16'h0000, 0, 1);
    // Unmapped address held for 20 cycles.
    xfer(0, 1'b1, 16'hFFF8, 16'hA5A5, 0, 20);
    xfer(0, 1'b0, 16'hFFF8, 16'h0000, 0, 20);
    // Abort in WAIT leaves the register untouched.
    xfer(0, 1'b1, 16'hFFF1, 16'hBEEF, 1, 0);
    xfer(0, 1'b0, 16'hFFF1, 16'h0000, 0, 0);
    // Reset while ready is high, then the register reads back its reset value.
    xfer(0, 1'b1, 16'hFFF0, 16'h1234, 0, 0);
    xfer(0, 1'b0, 16'hFFF0, 16'h0000, 2, 0);
    xfer(0, 1'b0, 16'hFFF0, 16'h0000, 0, 0);
    xfer(0, 1'b0, 16'hFFF3, 16'h0000, 0, 0);
    // Zero wait states, reads held in ACK while w is toggled.
    xfer(1, 1'b1, 16'hFFF5, 16'h3C5A, 0, 0);
    xfer(1, 1'b0, 16'hFFF5, 16'h0000, 0, 3);
    xfer(1, 1'b0, 16'hFFF7, 16'h0000, 0, 2);

`ifdef BUS_SLAVE_STATUS_EN
    do_reset();
    xfer(0, 1'b1, 16'hFFF2, 16'h0102, 0, 0);
    xfer(0, 1'b0, 16'hFFF2, 16'h0000, 0, 0);
    xfer(0, 1'b1, 16'hFFFF, 16'h7777, 0, 0);
    xfer(0, 1'b0, 16'hFFFF, 16'h0000, 0, 0);
    tick();
    dut0.status_q <= 16'hFFFF;
    scnt[0] = 16'hFFFF;
    xfer(0, 1'b1, 16'hFFF4, 16'h4444, 0, 0);
    xfer(0, 1'b0, 16'hFFFF, 16'h0000, 0, 0);
`endif

    for (int i = 0; i < 80; i++) begin
      int          k;
      int          sel;
      logic [15:0] a;
      bit          wr;
      int          mode;
      k   = $urandom_range(0, 1);
      sel = $urandom_range(0, 9);
      if (sel < 7) a = {BASE[15:4], 4'($urandom_range(0, NREGS - 1))};
      else if (sel < 8) a = {BASE[15:4], 4'($urandom_range(8, 15))};
      else a = 16'($urandom);
      wr   = 1'($urandom_range(0, 1));
      mode = (ws_of(k) > 0 && $urandom_range(0, 9) == 0) ? 1 : 0;
      xfer(k, wr, a, 16'($urandom), mode, $urandom_range(0, 2));
    end

    repeat (3) tick();
    check("sb_drain", 16'(q0.size() + q1.size()), 16'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
